// File: rtl/decoder_round_scheduler.sv
// Round-robin scheduler that shares one decoder among NUM_CHANNELS requesters and returns tagged results.
// Optional macro SCHED_LATENCY_EN adds an out_latency port (launch-to-completion cycle count).
module decoder_round_scheduler #(
   parameter int NUM_CHANNELS            = 4,
   parameter int ITERATION_COUNTER_WIDTH = 8,
   parameter int SETTLE_CYCLES           = 2,
   parameter int TIMEOUT_CYCLES          = 4096,
   localparam int CH_WIDTH               = $clog2(NUM_CHANNELS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CHANNELS-1:0]            req,
   output logic [NUM_CHANNELS-1:0]            grant,
   output logic                               busy,
   output logic                               new_round_start,
   input  logic                               dec_result_valid,
   input  logic                               dec_deadlock,
   input  logic                               dec_final_cardinality,
   input  logic [ITERATION_COUNTER_WIDTH-1:0] dec_iteration_counter,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [CH_WIDTH-1:0]                out_channel,
   output logic [1:0]                         out_status,
   output logic                               out_cardinality,
   output logic [ITERATION_COUNTER_WIDTH-1:0] out_iterations
`ifdef SCHED_LATENCY_EN
   ,
   output logic [31:0]                        out_latency
`endif
);

   localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_SETTLE,
      S_RUN,
      S_REPORT
   } state_t;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_DEADLOCK = 2'b01;
   localparam logic [1:0] ST_TIMEOUT  = 2'b10;

   state_t                               state_q, state_d;
   logic [CH_WIDTH-1:0]                  ptr_q, ptr_d;
   logic [CH_WIDTH-1:0]                  ch_q, ch_d;
   logic [WD_WIDTH-1:0]                  wd_q, wd_d;
   logic [CH_WIDTH-1:0]                  out_channel_q, out_channel_d;
   logic [1:0]                           out_status_q, out_status_d;
   logic                                 out_card_q, out_card_d;
   logic [ITERATION_COUNTER_WIDTH-1:0]   out_iter_q, out_iter_d;
`ifdef SCHED_LATENCY_EN
   logic [31:0]                          out_lat_q, out_lat_d;
`endif

   logic                found;
   logic [CH_WIDTH-1:0] pick;
   logic [CH_WIDTH-1:0] idx;
   logic                finish;
   logic [WD_WIDTH-1:0] wd_inc;

   // Search upward from the channel after the last grant so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      idx   = '0;
      for (int i = 1; i <= NUM_CHANNELS; i++) begin
         idx = CH_WIDTH'((int'(ptr_q) + i) % NUM_CHANNELS);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign wd_inc = (wd_q == '1) ? wd_q : wd_q + WD_WIDTH'(1);

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      ch_d          = ch_q;
      wd_d          = wd_q;
      out_channel_d = out_channel_q;
      out_status_d  = out_status_q;
      out_card_d    = out_card_q;
      out_iter_d    = out_iter_q;
      finish        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               ch_d    = pick;
               ptr_d   = pick;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            wd_d    = '0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            // Decoder status may still reflect the previous round here, so it is not looked at.
            wd_d = wd_inc;
            if (wd_q == WD_WIDTH'(SETTLE_CYCLES - 1)) state_d = S_RUN;
         end
         S_RUN: begin
            wd_d       = wd_inc;
            out_iter_d = dec_iteration_counter;
            out_card_d = 1'b0;
            if (dec_result_valid) begin
               finish       = 1'b1;
               out_status_d = ST_OK;
               out_card_d   = dec_final_cardinality;
            end else if (dec_deadlock) begin
               finish       = 1'b1;
               out_status_d = ST_DEADLOCK;
            end else if (wd_q == WD_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               finish       = 1'b1;
               out_status_d = ST_TIMEOUT;
            end
            if (finish) begin
               out_channel_d = ch_q;
               state_d       = S_REPORT;
            end else begin
               out_iter_d = out_iter_q;
               out_card_d = out_card_q;
            end
         end
         S_REPORT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef SCHED_LATENCY_EN
   // Completion happens during cycle t0+1+wd, so the inclusive span from launch is wd+2.
   assign out_lat_d = finish ? 32'(wd_q) + 32'd2 : out_lat_q;
`endif

   // NOTE: state uses non-blocking assignments and resets asynchronously so outputs clear at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= CH_WIDTH'(NUM_CHANNELS - 1);
         ch_q          <= '0;
         wd_q          <= '0;
         out_channel_q <= '0;
         out_status_q  <= '0;
         out_card_q    <= 1'b0;
         out_iter_q    <= '0;
`ifdef SCHED_LATENCY_EN
         out_lat_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         ch_q          <= ch_d;
         wd_q          <= wd_d;
         out_channel_q <= out_channel_d;
         out_status_q  <= out_status_d;
         out_card_q    <= out_card_d;
         out_iter_q    <= out_iter_d;
`ifdef SCHED_LATENCY_EN
         out_lat_q     <= out_lat_d;
`endif
      end
   end

   assign busy            = (state_q != S_IDLE);
   assign new_round_start = (state_q == S_LAUNCH);
   assign grant           = new_round_start ? (NUM_CHANNELS'(1) << ch_q) : '0;
   assign out_valid       = (state_q == S_REPORT);
   assign out_channel     = out_channel_q;
   assign out_status      = out_status_q;
   assign out_cardinality = out_card_q;
   assign out_iterations  = out_iter_q;
`ifdef SCHED_LATENCY_EN
   assign out_latency     = out_lat_q;
`endif

endmodule

// File: tb/tb_decoder_round_scheduler.sv
// Scoreboard bench for decoder_round_scheduler: stimulus queues expected grants/results, a monitor checks them.
module tb_decoder_round_scheduler;

   localparam int N   = 4;
   localparam int IW  = 8;
   localparam int CHW = $clog2(N);

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   grant;
   logic           busy;
   logic           new_round_start;
   logic           dec_rv;
   logic           dec_dl;
   logic           dec_fc;
   logic [IW-1:0]  dec_it;
   logic           out_valid;
   logic           out_ready;
   logic [CHW-1:0] out_channel;
   logic [1:0]     out_status;
   logic           out_cardinality;
   logic [IW-1:0]  out_iterations;
`ifdef SCHED_LATENCY_EN
   logic [31:0]    out_latency;
`endif

   decoder_round_scheduler #(
      .NUM_CHANNELS(N), .ITERATION_COUNTER_WIDTH(IW), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .reset(rst_n), .req(req), .grant(grant), .busy(busy),
      .new_round_start(new_round_start), .dec_result_valid(dec_rv), .dec_deadlock(dec_dl),
      .dec_final_cardinality(dec_fc), .dec_iteration_counter(dec_it), .out_valid(out_valid),
      .out_ready(out_ready), .out_channel(out_channel), .out_status(out_status),
      .out_cardinality(out_cardinality), .out_iterations(out_iterations)
`ifdef SCHED_LATENCY_EN
      , .out_latency(out_latency)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int st;
      int card;
      int iter;
      int delay;
   } exp_t;

   exp_t rq[$];
   int   gq[$];
   int   tests  = 0;
   int   failed = 0;
   int   cyc    = 0;
   int   t0     = 0;
   bit   valid_seen = 1'b1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_res(input int ch, input int st, input int card, input int iter, input int delay);
      exp_t e;
      e.ch = ch; e.st = st; e.card = card; e.iter = iter; e.delay = delay;
      rq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int max);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!new_round_start && n < max);
      if (!new_round_start) check("start_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin
         tick();
         n++;
      end
      check("idle_reached", int'(busy), 0);
   endtask

   task automatic wait_valid(input int max);
      int n = 0;
      while (!out_valid && n < max) begin
         tick();
         n++;
      end
      check("valid_reached", int'(out_valid), 1);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: checks grants against gq and accepted results against rq.
   always @(negedge clk) begin
      exp_t e;
      int   g;
      if (rst_n) begin
         if (new_round_start) begin
            if (gq.size() == 0) check("unexpected_start", 0, 1);
            else begin
               g = gq.pop_front();
               check("grant", int'(grant), 1 << g);
            end
            t0 = cyc;
            valid_seen = 1'b0;
         end else if (grant != '0) begin
            check("grant_without_start", int'(grant), 0);
         end
         if (out_valid && !valid_seen) begin
            valid_seen = 1'b1;
            if (rq.size() > 0) check("report_delay", cyc - t0, rq[0].delay);
         end
         if (out_valid && out_ready) begin
            if (rq.size() == 0) check("unexpected_result", 0, 1);
            else begin
               e = rq.pop_front();
               check("out_channel", int'(out_channel), e.ch);
               check("out_status", int'(out_status), e.st);
               check("out_cardinality", int'(out_cardinality), e.card);
               check("out_iterations", int'(out_iterations), e.iter);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; req = '0; dec_rv = 1'b0; dec_dl = 1'b0; dec_fc = 1'b0; dec_it = '0; out_ready = 1'b1;
      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_grant", int'(grant), 0);
      check("rst_start", int'(new_round_start), 0);
      check("rst_valid", int'(out_valid), 0);
      rst_n = 1'b1;
      tick();
      check("idle_busy", int'(busy), 0);

      // All channels requesting, results ready immediately: order 0,1,2,3,0.
      dec_rv = 1'b1; dec_fc = 1'b1; dec_it = 8'h11;
      foreach (gq[i]) ;
      for (int i = 0; i < 5; i++) begin
         gq.push_back(i % N);
         push_res(i % N, 0, 1, 8'h11, 4);
      end
      req = 4'b1111;
      for (int i = 0; i < 5; i++) wait_start(20);
      req = '0;
      wait_idle(20);
      dec_rv = 1'b0; dec_fc = 1'b0; dec_it = '0;
      tick();

      // Single requester, result 10 cycles after launch.
      gq.push_back(2);
      push_res(2, 0, 1, 3, 11);
      req = 4'b0100;
      wait_start(10);
      req = '0;
      repeat (10) tick();
      dec_rv = 1'b1; dec_fc = 1'b1; dec_it = 8'd3;
      tick();
      dec_rv = 1'b0; dec_fc = 1'b0; dec_it = '0;
      wait_idle(10);

      // Deadlock reports status 01 with cardinality forced to 0.
      gq.push_back(0);
      push_res(0, 1, 0, 7, 6);
      req = 4'b0001;
      wait_start(10);
      req = '0;
      repeat (5) tick();
      dec_dl = 1'b1; dec_fc = 1'b1; dec_it = 8'd7;
      tick();
      dec_dl = 1'b0; dec_fc = 1'b0; dec_it = '0;
      wait_idle(10);

      // result_valid and deadlock together: result_valid wins.
      gq.push_back(3);
      push_res(3, 0, 1, 9, 6);
      req = 4'b1000;
      wait_start(10);
      req = '0;
      repeat (5) tick();
      dec_rv = 1'b1; dec_dl = 1'b1; dec_fc = 1'b1; dec_it = 8'd9;
      tick();
      dec_rv = 1'b0; dec_dl = 1'b0; dec_fc = 1'b0; dec_it = '0;
      wait_idle(10);

      // Silent decoder: watchdog timeout, out_valid first high at t0+65.
      gq.push_back(1);
      push_res(1, 2, 0, 8'h42, 65);
      dec_fc = 1'b1; dec_it = 8'h42;
      req = 4'b0010;
      wait_start(10);
      req = '0;
      wait_idle(100);
      dec_fc = 1'b0; dec_it = '0;

      // Stale result_valid through settle must be ignored; later assertion completes the round.
      gq.push_back(2);
      push_res(2, 0, 0, 8'h20, 24);
      dec_rv = 1'b1; dec_fc = 1'b1; dec_it = 8'h99;
      req = 4'b0100;
      wait_start(10);
      req = '0;
      repeat (2) tick();
      check("stale_ignored_busy", int'(busy), 1);
      tick();
      dec_rv = 1'b0;
      repeat (20) tick();
      dec_rv = 1'b1; dec_fc = 1'b0; dec_it = 8'h20;
      tick();
      dec_rv = 1'b0; dec_it = '0;
      wait_idle(10);

      // Backpressure: outputs held, no grant while a request is pending.
      out_ready = 1'b0;
      gq.push_back(0);
      push_res(0, 0, 1, 4, 4);
      req = 4'b0011;
      wait_start(10);
      dec_rv = 1'b1; dec_fc = 1'b1; dec_it = 8'd4;
      wait_valid(10);
      dec_rv = 1'b0; dec_fc = 1'b0; dec_it = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", int'(out_valid), 1);
         check("hold_busy", int'(busy), 1);
         check("hold_grant", int'(grant), 0);
         check("hold_channel", int'(out_channel), 0);
         check("hold_status", int'(out_status), 0);
         check("hold_card", int'(out_cardinality), 1);
         check("hold_iter", int'(out_iterations), 4);
      end
      gq.push_back(1);
      out_ready = 1'b1;
      tick();
      check("after_accept_start", int'(new_round_start), 0);
      tick();
      check("next_grant_at_accept_plus2", int'(grant), 4'b0010);
      req = '0;
      repeat (4) tick();
      check("mid_run_busy", int'(busy), 1);

      // Asynchronous reset mid-round: outputs clear at once, round abandoned.
      rst_n = 1'b0;
      #1;
      check("areset_busy", int'(busy), 0);
      check("areset_valid", int'(out_valid), 0);
      check("areset_grant", int'(grant), 0);
      check("areset_start", int'(new_round_start), 0);
      check("areset_channel", int'(out_channel), 0);
      check("areset_status", int'(out_status), 0);
      check("areset_card", int'(out_cardinality), 0);
      check("areset_iter", int'(out_iterations), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      gq.push_back(0);
      push_res(0, 0, 1, 5, 4);
      dec_rv = 1'b1; dec_fc = 1'b1; dec_it = 8'd5;
      req = 4'b0011;
      wait_start(10);
      req = '0;
      wait_idle(20);
      dec_rv = 1'b0; dec_fc = 1'b0; dec_it = '0;
      repeat (3) tick();

      check("grants_left", gq.size(), 0);
      check("results_left", rq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
